ifetch_buffer: RTL and testbench



---
 rtl/ifetch_buffer.sv | 146 ++++++++++++++
 tb/tb_ifetch_buffer.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_buffer.sv
// Instruction fetch stage for mcu0.
// Samples the PC, issues one memory read at a time, and pulses the PC register's
// load input. Returned words are queued with their PC in a small FIFO for decode.
// A flush from the decoder empties the FIFO. A fetch that is still outstanding
// during a flush is allowed to complete, and its data is then dropped.
module ifetch_buffer #(
  parameter int AW    = 16,
  parameter int DW    = 16,
  parameter int DEPTH = 2
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [AW-1:0] pc_i,
  output logic          pc_step,
  input  logic          flush,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  output logic          ir_valid,
  output logic [DW-1:0] ir_data,
  output logic [AW-1:0] ir_pc,
  input  logic          ir_ready
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  // REQ waits for the data of a live fetch.
  // DROP waits out a fetch that a flush has already cancelled.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic          req_d;
  logic          step_d;
  logic [AW-1:0] addr_d;
  logic          push;
  logic          pop;

  logic [CW-1:0] count_q;
  logic [PW-1:0] rd_ptr_q;
  logic [PW-1:0] wr_ptr_q;
  logic [DW-1:0] data_mem [DEPTH];
  logic [AW-1:0] pc_mem   [DEPTH];

  // Decode hands over the head entry; a flush overrides the handshake
  assign pop = ir_valid && ir_ready && !flush;

  // Next-state logic.
  // A new fetch issues only from IDLE, and only when the FIFO has room.
  // The room check uses the count before any same-cycle pop.
  always_comb begin
    state_d = state_q;
    req_d   = mem_req;
    addr_d  = mem_addr;
    step_d  = 1'b0;
    push    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!flush && (count_q < FULL_CNT)) begin
          state_d = REQ;
          req_d   = 1'b1;
          addr_d  = pc_i;
          step_d  = 1'b1;
        end
      end
      REQ: begin
        if (mem_ack) begin
          state_d = IDLE;
          req_d   = 1'b0;
          push    = !flush;
        end else if (flush) begin
          state_d = DROP;
        end
      end
      DROP: begin
        if (mem_ack) begin
          state_d = IDLE;
          req_d   = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  // Fetch control registers.
  // pc_step goes high only in the first REQ cycle.
  // mem_addr stays fixed for as long as the request is outstanding.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      mem_req  <= 1'b0;
      mem_addr <= '0;
      pc_step  <= 1'b0;
    end else begin
      state_q  <= state_d;
      mem_req  <= req_d;
      mem_addr <= addr_d;
      pc_step  <= step_d;
    end
  end

  // FIFO occupancy and pointers. A flush empties the queue in one cycle.
  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      if (push && !pop) begin
        count_q <= count_q + CW'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CW'(1);
      end
    end
  end

  // FIFO storage. These registers hold data only and are never reset.
  always_ff @(posedge clock) begin
    if (push) begin
      data_mem[wr_ptr_q] <= mem_rdata;
      pc_mem[wr_ptr_q]   <= mem_addr;
    end
  end

  assign ir_valid = (count_q != '0);
  assign ir_data  = data_mem[rd_ptr_q];
  assign ir_pc    = pc_mem[rd_ptr_q];

endmodule

// File: tb/tb_ifetch_buffer.sv
// Testbench for ifetch_buffer.
// The environment models a PC register (adds 2 on pc_step, cleared by reset) and an
// instruction memory image. In automatic mode it answers each read with a chosen
// latency; otherwise the individual tests drive acks by hand.
module tb_ifetch_buffer;

  localparam int AW    = 16;
  localparam int DW    = 16;
  localparam int DEPTH = 2;

  logic          clock;
  logic          reset;
  logic [AW-1:0] pc_i;
  logic          pc_step;
  logic          flush;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;
  logic          ir_valid;
  logic [DW-1:0] ir_data;
  logic [AW-1:0] ir_pc;
  logic          ir_ready;

  logic [DW-1:0] mem_img [0:1023];
  logic [AW-1:0] pc_reg;
  int            checks;
  int            failures;
  bit            auto_mem;
  bit            rand_lat;
  int            req_age;
  int            cur_lat;

  ifetch_buffer #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
    .clock    (clock),
    .reset    (reset),
    .pc_i     (pc_i),
    .pc_step  (pc_step),
    .flush    (flush),
    .mem_req  (mem_req),
    .mem_addr (mem_addr),
    .mem_ack  (mem_ack),
    .mem_rdata(mem_rdata),
    .ir_valid (ir_valid),
    .ir_data  (ir_data),
    .ir_pc    (ir_pc),
    .ir_ready (ir_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one clock. Outputs are sampled 1 time unit after the edge, and the
  // environment (PC register, memory) is updated in that same slot.
  task automatic cyc();
    logic step_was;
    logic rst_was;
    step_was = pc_step;
    rst_was  = reset;
    @(posedge clock);
    #1;
    if (rst_was) pc_reg = '0;
    else if (step_was === 1'b1) pc_reg = pc_reg + 16'd2;
    pc_i    = pc_reg;
    mem_ack = 1'b0;
    if (mem_req === 1'b1) begin
      if (auto_mem) begin
        if (req_age == 0) cur_lat = rand_lat ? int'($urandom_range(5, 1)) : 1;
        if (req_age == cur_lat - 1) begin
          mem_ack   = 1'b1;
          mem_rdata = mem_img[mem_addr[10:1]];
        end
      end
      req_age++;
    end else begin
      req_age = 0;
    end
  endtask

  task automatic set_pc(input logic [AW-1:0] v);
    pc_reg = v;
    pc_i   = v;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    flush    = 1'b0;
    ir_ready = 1'b0;
    mem_ack  = 1'b0;
    auto_mem = 1'b0;
    rand_lat = 1'b0;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL rst_mem_req got=%h exp=0", mem_req); end
    checks++; if (pc_step !== 1'b0) begin failures++; $display("FAIL rst_pc_step got=%h exp=0", pc_step); end
    checks++; if (ir_valid !== 1'b0) begin failures++; $display("FAIL rst_ir_valid got=%h exp=0", ir_valid); end
    checks++; if (mem_addr !== 16'h0000) begin failures++; $display("FAIL rst_mem_addr got=%h exp=0000", mem_addr); end
  endtask

  task automatic test_basic();
    do_reset();
    mem_img[0] = 16'h1234;
    mem_img[1] = 16'h5678;
    set_pc(16'h0000);
    auto_mem = 1'b1;
    ir_ready = 1'b1;
    cyc();
    checks++; if ({mem_req, pc_step} !== 2'b11) begin failures++; $display("FAIL basic_issue got=%b exp=11", {mem_req, pc_step}); end
    checks++; if (mem_addr !== 16'h0000) begin failures++; $display("FAIL basic_addr0 got=%h exp=0000", mem_addr); end
    cyc();
    checks++; if ({ir_valid, ir_pc, ir_data} !== {1'b1, 16'h0000, 16'h1234}) begin
      failures++; $display("FAIL basic_head got=%h exp=%h", {ir_valid, ir_pc, ir_data}, {1'b1, 16'h0000, 16'h1234}); end
    checks++; if ({mem_req, pc_step} !== 2'b00) begin failures++; $display("FAIL basic_idle got=%b exp=00", {mem_req, pc_step}); end
    cyc();
    checks++; if ({mem_req, pc_step} !== 2'b11) begin failures++; $display("FAIL basic_issue2 got=%b exp=11", {mem_req, pc_step}); end
    checks++; if (mem_addr !== 16'h0002) begin failures++; $display("FAIL basic_addr2 got=%h exp=0002", mem_addr); end
    checks++; if (ir_valid !== 1'b0) begin failures++; $display("FAIL basic_popped got=%h exp=0", ir_valid); end
  endtask

  task automatic test_full();
    do_reset();
    mem_img[0] = 16'h00A0;
    mem_img[1] = 16'h00A1;
    mem_img[2] = 16'h00A2;
    set_pc(16'h0000);
    auto_mem = 1'b1;
    ir_ready = 1'b0;
    repeat (6) cyc();
    for (int i = 0; i < 6; i++) begin
      cyc();
      checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL full_no_req got=%h exp=0", mem_req); end
      checks++; if ({ir_valid, ir_pc, ir_data} !== {1'b1, 16'h0000, 16'h00A0}) begin
        failures++; $display("FAIL full_head got=%h exp=%h", {ir_valid, ir_pc, ir_data}, {1'b1, 16'h0000, 16'h00A0}); end
    end
    ir_ready = 1'b1;
    cyc();
    checks++; if ({ir_valid, ir_pc, ir_data} !== {1'b1, 16'h0002, 16'h00A1}) begin
      failures++; $display("FAIL full_second got=%h exp=%h", {ir_valid, ir_pc, ir_data}, {1'b1, 16'h0002, 16'h00A1}); end
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL full_still_no_req got=%h exp=0", mem_req); end
    cyc();
    checks++; if ({mem_req, mem_addr} !== {1'b1, 16'h0004}) begin
      failures++; $display("FAIL full_third_issue got=%h exp=%h", {mem_req, mem_addr}, {1'b1, 16'h0004}); end
    checks++; if (ir_valid !== 1'b0) begin failures++; $display("FAIL full_drained got=%h exp=0", ir_valid); end
    cyc();
    checks++; if ({ir_valid, ir_pc, ir_data} !== {1'b1, 16'h0004, 16'h00A2}) begin
      failures++; $display("FAIL full_third got=%h exp=%h", {ir_valid, ir_pc, ir_data}, {1'b1, 16'h0004, 16'h00A2}); end
  endtask

  task automatic test_flush_drop();
    do_reset();
    mem_img[16'h0080] = 16'hBEEF;
    set_pc(16'h0040);
    ir_ready = 1'b1;
    cyc();
    checks++; if ({mem_req, mem_addr} !== {1'b1, 16'h0040}) begin
      failures++; $display("FAIL drop_issue got=%h exp=%h", {mem_req, mem_addr}, {1'b1, 16'h0040}); end
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    set_pc(16'h0100);
    checks++; if ({mem_req, pc_step, mem_addr} !== {2'b10, 16'h0040}) begin
      failures++; $display("FAIL drop_held got=%h exp=%h", {mem_req, pc_step, mem_addr}, {2'b10, 16'h0040}); end
    cyc();
    checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL drop_held2 got=%h exp=1", mem_req); end
    cyc();
    checks++; if ({mem_req, ir_valid} !== 2'b10) begin failures++; $display("FAIL drop_held3 got=%b exp=10", {mem_req, ir_valid}); end
    mem_ack   = 1'b1;
    mem_rdata = 16'hDEAD;
    cyc();
    checks++; if ({mem_req, ir_valid} !== 2'b00) begin failures++; $display("FAIL drop_discard got=%b exp=00", {mem_req, ir_valid}); end
    cyc();
    checks++; if ({mem_req, pc_step, mem_addr} !== {2'b11, 16'h0100}) begin
      failures++; $display("FAIL drop_redirect got=%h exp=%h", {mem_req, pc_step, mem_addr}, {2'b11, 16'h0100}); end
    mem_ack   = 1'b1;
    mem_rdata = mem_img[16'h0080];
    cyc();
    checks++; if ({ir_valid, ir_pc, ir_data} !== {1'b1, 16'h0100, 16'hBEEF}) begin
      failures++; $display("FAIL drop_newhead got=%h exp=%h", {ir_valid, ir_pc, ir_data}, {1'b1, 16'h0100, 16'hBEEF}); end
  endtask

  task automatic test_flush_ack_pop();
    // FIFO full; the flush coincides with a pop and a stray ack
    do_reset();
    mem_img[0] = 16'h0111;
    mem_img[1] = 16'h0222;
    mem_img[2] = 16'h0333;
    set_pc(16'h0000);
    auto_mem = 1'b1;
    ir_ready = 1'b0;
    repeat (6) cyc();
    checks++; if ({ir_valid, ir_pc} !== {1'b1, 16'h0000}) begin
      failures++; $display("FAIL fap_full got=%h exp=%h", {ir_valid, ir_pc}, {1'b1, 16'h0000}); end
    auto_mem  = 1'b0;
    flush     = 1'b1;
    ir_ready  = 1'b1;
    mem_ack   = 1'b1;
    mem_rdata = 16'h7777;
    cyc();
    ir_ready = 1'b0;
    checks++; if ({ir_valid, mem_req, pc_step} !== 3'b000) begin
      failures++; $display("FAIL fap_empty got=%b exp=000", {ir_valid, mem_req, pc_step}); end
    cyc();
    flush = 1'b0;
    checks++; if ({ir_valid, mem_req, pc_step} !== 3'b000) begin
      failures++; $display("FAIL fap_no_issue_in_flush got=%b exp=000", {ir_valid, mem_req, pc_step}); end
    cyc();
    checks++; if ({mem_req, mem_addr} !== {1'b1, 16'h0004}) begin
      failures++; $display("FAIL fap_resume got=%h exp=%h", {mem_req, mem_addr}, {1'b1, 16'h0004}); end
    mem_ack   = 1'b1;
    mem_rdata = mem_img[2];
    cyc();
    checks++; if ({ir_valid, ir_pc, ir_data} !== {1'b1, 16'h0004, 16'h0333}) begin
      failures++; $display("FAIL fap_resume_head got=%h exp=%h", {ir_valid, ir_pc, ir_data}, {1'b1, 16'h0004, 16'h0333}); end
    // a fetch is in REQ; flush arrives together with its ack and a pop
    do_reset();
    set_pc(16'h0000);
    auto_mem = 1'b1;
    ir_ready = 1'b0;
    cyc();
    cyc();
    auto_mem = 1'b0;
    cyc();
    checks++; if ({mem_req, mem_addr, ir_valid} !== {1'b1, 16'h0002, 1'b1}) begin
      failures++; $display("FAIL fap_req got=%h exp=%h", {mem_req, mem_addr, ir_valid}, {1'b1, 16'h0002, 1'b1}); end
    flush     = 1'b1;
    mem_ack   = 1'b1;
    mem_rdata = 16'h9999;
    ir_ready  = 1'b1;
    cyc();
    flush    = 1'b0;
    ir_ready = 1'b0;
    checks++; if ({ir_valid, mem_req} !== 2'b00) begin failures++; $display("FAIL fap_ack_flush got=%b exp=00", {ir_valid, mem_req}); end
    auto_mem = 1'b1;
    cyc();
    checks++; if ({mem_req, mem_addr} !== {1'b1, 16'h0004}) begin
      failures++; $display("FAIL fap_ack_resume got=%h exp=%h", {mem_req, mem_addr}, {1'b1, 16'h0004}); end
    cyc();
    checks++; if ({ir_valid, ir_pc, ir_data} !== {1'b1, 16'h0004, 16'h0333}) begin
      failures++; $display("FAIL fap_ack_head got=%h exp=%h", {ir_valid, ir_pc, ir_data}, {1'b1, 16'h0004, 16'h0333}); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    mem_img[16'h0018] = 16'h4321;
    set_pc(16'h0020);
    ir_ready = 1'b1;
    cyc();
    checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL rmid_req got=%h exp=1", mem_req); end
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    checks++; if ({mem_req, pc_step, ir_valid} !== 3'b000) begin
      failures++; $display("FAIL rmid_abandon got=%b exp=000", {mem_req, pc_step, ir_valid}); end
    set_pc(16'h0030);
    mem_ack   = 1'b1;
    mem_rdata = 16'h5555;
    cyc();
    checks++; if ({mem_req, mem_addr, ir_valid} !== {1'b1, 16'h0030, 1'b0}) begin
      failures++; $display("FAIL rmid_stray got=%h exp=%h", {mem_req, mem_addr, ir_valid}, {1'b1, 16'h0030, 1'b0}); end
    cyc();
    checks++; if ({mem_req, ir_valid} !== 2'b10) begin failures++; $display("FAIL rmid_wait got=%b exp=10", {mem_req, ir_valid}); end
    mem_ack   = 1'b1;
    mem_rdata = mem_img[16'h0018];
    cyc();
    checks++; if ({ir_valid, ir_pc, ir_data} !== {1'b1, 16'h0030, 16'h4321}) begin
      failures++; $display("FAIL rmid_head got=%h exp=%h", {ir_valid, ir_pc, ir_data}, {1'b1, 16'h0030, 16'h4321}); end
  endtask

  task automatic test_random();
    logic [AW-1:0] start;
    logic [AW-1:0] exp_pop;
    logic [AW-1:0] exp_iss;
    int            pops;
    int            issues;
    int            steps;
    int            ncyc;
    logic          req_prev;
    do_reset();
    start = 16'(2 * $urandom_range(100, 0));
    set_pc(start);
    auto_mem = 1'b1;
    rand_lat = 1'b1;
    exp_pop  = start;
    exp_iss  = start;
    pops     = 0;
    issues   = 0;
    steps    = 0;
    ncyc     = 0;
    req_prev = 1'b0;
    while (pops < 200 && ncyc < 8000) begin
      ir_ready = ($urandom_range(3, 0) != 0);
      if (ir_valid === 1'b1 && ir_ready) begin
        checks++; if (ir_pc !== exp_pop) begin failures++; $display("FAIL rnd_pc got=%h exp=%h", ir_pc, exp_pop); end
        checks++; if (ir_data !== mem_img[exp_pop[10:1]]) begin
          failures++; $display("FAIL rnd_data got=%h exp=%h", ir_data, mem_img[exp_pop[10:1]]); end
        exp_pop = exp_pop + 16'd2;
        pops++;
      end
      cyc();
      ncyc++;
      if (pc_step === 1'b1) steps++;
      if (mem_req === 1'b1 && !req_prev) begin
        checks++; if (mem_addr !== exp_iss) begin failures++; $display("FAIL rnd_issue_addr got=%h exp=%h", mem_addr, exp_iss); end
        exp_iss = exp_iss + 16'd2;
        issues++;
      end
      req_prev = mem_req;
    end
    ir_ready = 1'b0;
    checks++; if (pops != 200) begin failures++; $display("FAIL rnd_pop_count got=%0d exp=200", pops); end
    checks++; if (steps != issues) begin failures++; $display("FAIL rnd_steps got=%0d exp=%0d", steps, issues); end
    checks++; if (issues < pops || issues - pops > DEPTH + 1) begin
      failures++; $display("FAIL rnd_inflight got=%0d exp=0..%0d", issues - pops, DEPTH + 1); end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    reset     = 1'b1;
    flush     = 1'b0;
    ir_ready  = 1'b0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    pc_reg    = '0;
    pc_i      = '0;
    auto_mem  = 1'b0;
    rand_lat  = 1'b0;
    req_age   = 0;
    cur_lat   = 1;
    for (int i = 0; i < 1024; i++) mem_img[i] = 16'($urandom);
    test_reset();
    test_basic();
    test_full();
    test_flush_drop();
    test_flush_ack_pop();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

endmodule
